// File: rtl/router_pkg.sv
// Shared router types and helpers: port count, port status, allocator
// state encoding and a round-robin pick function.
package router_pkg;

   localparam int unsigned NUM_OF_PORTS = 5;
   localparam int unsigned PORT_IDX_W   = $clog2(NUM_OF_PORTS);

   typedef enum logic {
      PORT_FREE = 1'b0,
      PORT_BUSY = 1'b1
   } PORT_STATUS_t;

   typedef enum logic {
      ALLOC_IDLE   = 1'b0,
      ALLOC_ACTIVE = 1'b1
   } alloc_state_t;

   // First set bit of eligible at or after ptr, wrapping; 0 when none is set.
   function automatic logic [PORT_IDX_W-1:0] rr_pick(
      input logic [NUM_OF_PORTS-1:0] eligible,
      input logic [PORT_IDX_W-1:0]   ptr
   );
      logic [PORT_IDX_W-1:0] pick;
      logic                  found;
      int unsigned           j;
      pick  = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < NUM_OF_PORTS; k++) begin
         j = (32'(ptr) + k) % NUM_OF_PORTS;
         if (!found && eligible[PORT_IDX_W'(j)]) begin
            found = 1'b1;
            pick  = PORT_IDX_W'(j);
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first eligible requester at or
// after ptr, wrapping mod N. Outputs are all-zero when nothing is eligible.
module rr_arbiter #(
   parameter  int unsigned N     = 5,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     eligible,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] index
);

   logic        found;
   int unsigned j;

   always_comb begin
      onehot = '0;
      index  = '0;
      found  = 1'b0;
      j      = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (32'(ptr) + k) % N;
         if (!found && eligible[IDX_W'(j)]) begin
            found                = 1'b1;
            onehot[IDX_W'(j)]    = 1'b1;
            index                = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output-port switch allocator: round-robin arbitration over input
// units, wormhole lock from head to tail, credit-gated flit transfer.
module output_port_allocator #(
   parameter  int unsigned NUM_OF_PORTS = router_pkg::NUM_OF_PORTS,
   parameter  int unsigned CREDITS      = 4,
   localparam int unsigned CNT_W        = $clog2(CREDITS + 1),
   localparam int unsigned IDX_W        = $clog2(NUM_OF_PORTS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_OF_PORTS-1:0] i_req,
   input  logic [NUM_OF_PORTS-1:0] i_valid,
   input  logic [NUM_OF_PORTS-1:0] i_head,
   input  logic [NUM_OF_PORTS-1:0] i_tail,
   input  logic                    i_credit_return,
   output logic [NUM_OF_PORTS-1:0] o_grant,
   output logic [IDX_W-1:0]        o_sel,
   output logic                    o_xfer,
   output logic                    o_busy,
   output logic [CNT_W-1:0]        o_credits,
   output logic                    o_credit_err
);

   import router_pkg::*;

   alloc_state_t            state, state_nxt;
   PORT_STATUS_t            port_status, port_status_nxt;
   logic [NUM_OF_PORTS-1:0] grant_nxt;
   logic [IDX_W-1:0]        sel_nxt;
   logic [IDX_W-1:0]        rr_ptr, rr_ptr_nxt;
   logic [CNT_W-1:0]        credits, credits_nxt;
   logic                    credit_err_nxt;

   logic [NUM_OF_PORTS-1:0] eligible;
   logic [NUM_OF_PORTS-1:0] win_onehot;
   logic [IDX_W-1:0]        win_idx;
   logic                    credit_ok;

   assign eligible  = i_req & i_valid & i_head;
   assign credit_ok = (credits != '0);
   assign o_xfer    = (state == ALLOC_ACTIVE) && i_valid[o_sel] && credit_ok;
   assign o_busy    = (port_status == PORT_BUSY);
   assign o_credits = credits;

   rr_arbiter #(
      .N (NUM_OF_PORTS)
   ) u_rr_arbiter (
      .eligible (eligible),
      .ptr      (rr_ptr),
      .onehot   (win_onehot),
      .index    (win_idx)
   );

   // Next-state: arbitration in IDLE, lock release on the owner's tail.
   always_comb begin
      state_nxt       = state;
      grant_nxt       = o_grant;
      sel_nxt         = o_sel;
      rr_ptr_nxt      = rr_ptr;
      credits_nxt     = credits;
      credit_err_nxt  = o_credit_err;

      case (state)
         ALLOC_IDLE: begin
            if ((eligible != '0) && credit_ok) begin
               state_nxt = ALLOC_ACTIVE;
               grant_nxt = win_onehot;
               sel_nxt   = win_idx;
            end
         end
         ALLOC_ACTIVE: begin
            if (o_xfer && i_tail[o_sel]) begin
               state_nxt  = ALLOC_IDLE;
               grant_nxt  = '0;
               rr_ptr_nxt = (o_sel == IDX_W'(NUM_OF_PORTS - 1)) ? '0 : o_sel + IDX_W'(1);
            end
         end
         default: begin
            state_nxt = ALLOC_IDLE;
            grant_nxt = '0;
         end
      endcase

      // A transfer and a return in the same cycle cancel out.
      if (o_xfer && !i_credit_return) begin
         credits_nxt = credits - CNT_W'(1);
      end else if (!o_xfer && i_credit_return) begin
         if (credits == CNT_W'(CREDITS)) begin
            credit_err_nxt = 1'b1;
         end else begin
            credits_nxt = credits + CNT_W'(1);
         end
      end

      port_status_nxt = (state_nxt == ALLOC_ACTIVE) ? PORT_BUSY : PORT_FREE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ALLOC_IDLE;
         port_status  <= PORT_FREE;
         o_grant      <= '0;
         o_sel        <= '0;
         rr_ptr       <= '0;
         credits      <= CNT_W'(CREDITS);
         o_credit_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         port_status  <= port_status_nxt;
         o_grant      <= grant_nxt;
         o_sel        <= sel_nxt;
         rr_ptr       <= rr_ptr_nxt;
         credits      <= credits_nxt;
         o_credit_err <= credit_err_nxt;
      end
   end

endmodule

// File: tb/tb_output_port_allocator.sv
// Scoreboard bench for output_port_allocator: upstream source model drives
// packets, expected owners are queued per flit and checked on each o_xfer.
module tb_output_port_allocator;

   logic       clk;
   logic       reset;
   logic [4:0] i_req, i_valid, i_head, i_tail;
   logic       i_credit_return;
   logic [4:0] o_grant;
   logic [2:0] o_sel;
   logic       o_xfer;
   logic       o_busy;
   logic [2:0] o_credits;
   logic       o_credit_err;

   output_port_allocator #(
      .NUM_OF_PORTS (5),
      .CREDITS      (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .i_req           (i_req),
      .i_valid         (i_valid),
      .i_head          (i_head),
      .i_tail          (i_tail),
      .i_credit_return (i_credit_return),
      .o_grant         (o_grant),
      .o_sel           (o_sel),
      .o_xfer          (o_xfer),
      .o_busy          (o_busy),
      .o_credits       (o_credits),
      .o_credit_err    (o_credit_err)
   );

   int errors = 0;
   int checks = 0;
   int sb[$];

   // Upstream source model, one entry per input port
   int pkts_left[5];
   int plen[5];
   int fidx[5];
   int gap_at[5];
   int gap_left[5];
   logic cr_echo;
   int   cr_pulses;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_n(input int owner, input int n);
      for (int k = 0; k < n; k++) sb.push_back(owner);
   endtask

   task automatic load(input int p, input int npkts, input int len, input int gat, input int glen);
      pkts_left[p] = npkts;
      plen[p]      = len;
      fidx[p]      = 0;
      gap_at[p]    = gat;
      gap_left[p]  = glen;
   endtask

   task automatic flush();
      for (int p = 0; p < 5; p++) load(p, 0, 1, -1, 0);
   endtask

   task automatic drive();
      logic act, gap;
      for (int p = 0; p < 5; p++) begin
         act = (pkts_left[p] > 0);
         gap = act && (fidx[p] == gap_at[p]) && (gap_left[p] > 0);
         if (gap) gap_left[p]--;
         i_req[p]   = act;
         i_valid[p] = act && !gap;
         i_head[p]  = (fidx[p] == 0);
         i_tail[p]  = (fidx[p] == plen[p] - 1);
      end
   endtask

   // Observe this cycle's transfer, then advance sources and drive the next cycle.
   task automatic cycle();
      logic       x;
      logic [2:0] s;
      int         si;
      @(negedge clk);
      x = (o_xfer === 1'b1);
      s = o_sel;
      @(posedge clk);
      #1;
      si = int'(s);
      if (x && si < 5) begin
         fidx[si]++;
         if (fidx[si] == plen[si]) begin
            fidx[si] = 0;
            pkts_left[si]--;
         end
      end
      i_credit_return = (cr_echo && x) || (cr_pulses > 0);
      if (cr_pulses > 0) cr_pulses--;
      drive();
      #1;
   endtask

   // Monitor: every transfer must match the next expected owner.
   initial begin
      int exp_owner;
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && o_xfer === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_xfer", 32'(o_sel), 32'hFF);
            end else begin
               exp_owner = sb.pop_front();
               chk("xfer_sel", 32'(o_sel), 32'(exp_owner));
               chk("xfer_grant", 32'(o_grant), 32'(1) << exp_owner);
            end
         end
      end
   end

   initial begin
      reset           = 1'b1;
      i_credit_return = 1'b0;
      cr_echo         = 1'b0;
      cr_pulses       = 0;
      flush();
      drive();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      cycle();
      chk("por_grant", 32'(o_grant), 0);
      chk("por_sel", 32'(o_sel), 0);
      chk("por_busy", 32'(o_busy), 0);
      chk("por_credits", 32'(o_credits), 4);
      chk("por_err", 32'(o_credit_err), 0);

      // Round-robin fairness: inputs 0,2,4 with two 2-flit packets each
      cr_echo = 1'b1;
      load(0, 2, 2, -1, 0);
      load(2, 2, 2, -1, 0);
      load(4, 2, 2, -1, 0);
      for (int r = 0; r < 2; r++) begin
         push_n(0, 2); push_n(2, 2); push_n(4, 2);
      end
      repeat (22) cycle();
      chk("rr_drained", 32'(sb.size()), 0);
      chk("rr_busy", 32'(o_busy), 0);
      chk("rr_credits", 32'(o_credits), 4);
      chk("rr_err", 32'(o_credit_err), 0);
      cr_echo = 1'b0;

      // Credit stall: 6-flit packet on input 1 with no returns
      load(1, 1, 6, -1, 0);
      push_n(1, 5);
      repeat (8) cycle();
      chk("stall_xfer", 32'(o_xfer), 0);
      chk("stall_credits", 32'(o_credits), 0);
      chk("stall_grant", 32'(o_grant), 32'h02);
      chk("stall_busy", 32'(o_busy), 1);
      cr_pulses = 1;
      repeat (4) cycle();
      chk("one_ret_drained", 32'(sb.size()), 0);
      chk("one_ret_credits", 32'(o_credits), 0);
      chk("one_ret_xfer", 32'(o_xfer), 0);
      chk("one_ret_grant", 32'(o_grant), 32'h02);
      push_n(1, 1);
      cr_pulses = 5;
      repeat (6) cycle();
      chk("stall_done_drained", 32'(sb.size()), 0);
      chk("stall_done_busy", 32'(o_busy), 0);
      chk("stall_done_credits", 32'(o_credits), 4);

      // Simultaneous transfer and return at credits=2, then overflow
      load(3, 1, 4, -1, 0);
      push_n(3, 4);
      repeat (3) cycle();
      cr_pulses = 1;
      cycle();
      chk("simul_xfer", 32'(o_xfer), 1);
      chk("simul_credits_before", 32'(o_credits), 2);
      cycle();
      chk("simul_credits_after", 32'(o_credits), 2);
      cr_pulses = 3;
      repeat (4) cycle();
      chk("refill_credits", 32'(o_credits), 4);
      chk("refill_err", 32'(o_credit_err), 0);
      cr_pulses = 1;
      repeat (2) cycle();
      chk("ovf_credits", 32'(o_credits), 4);
      chk("ovf_err", 32'(o_credit_err), 1);
      repeat (3) cycle();
      chk("ovf_err_sticky", 32'(o_credit_err), 1);
      chk("simul_drained", 32'(sb.size()), 0);

      // Pointer at 4: single-flit packets from inputs 4 and 0
      cr_echo = 1'b1;
      load(4, 1, 1, -1, 0);
      load(0, 1, 1, -1, 0);
      push_n(4, 1);
      push_n(0, 1);
      repeat (2) cycle();
      chk("wrap_g4_grant", 32'(o_grant), 32'h10);
      chk("wrap_g4_xfer", 32'(o_xfer), 1);
      cycle();
      chk("wrap_idle_grant", 32'(o_grant), 0);
      chk("wrap_idle_busy", 32'(o_busy), 0);
      cycle();
      chk("wrap_g0_grant", 32'(o_grant), 32'h01);
      chk("wrap_g0_xfer", 32'(o_xfer), 1);
      cycle();
      chk("wrap_end_busy", 32'(o_busy), 0);
      cr_echo = 1'b0;
      cycle();
      chk("wrap_credits", 32'(o_credits), 4);

      // Bubble on owner 1 (pointer now 1), input 0 also waiting
      load(1, 1, 4, 2, 2);
      load(0, 1, 1, -1, 0);
      push_n(1, 4);
      push_n(0, 1);
      repeat (4) cycle();
      chk("bub1_xfer", 32'(o_xfer), 0);
      chk("bub1_credits", 32'(o_credits), 2);
      chk("bub1_grant", 32'(o_grant), 32'h02);
      cycle();
      chk("bub2_xfer", 32'(o_xfer), 0);
      chk("bub2_credits", 32'(o_credits), 2);
      chk("bub2_grant", 32'(o_grant), 32'h02);
      repeat (2) cycle();
      chk("bub_tail_xfer", 32'(o_xfer), 1);
      cycle();
      chk("bub_release_busy", 32'(o_busy), 0);
      chk("bub_release_credits", 32'(o_credits), 0);
      repeat (3) cycle();
      chk("zero_credit_no_grant", 32'(o_grant), 0);
      chk("zero_credit_busy", 32'(o_busy), 0);
      cr_pulses = 4;
      repeat (5) cycle();
      chk("bub_drained", 32'(sb.size()), 0);
      chk("bub_credits", 32'(o_credits), 3);
      chk("bub_err_sticky", 32'(o_credit_err), 1);

      // Reset in the middle of a packet on input 2
      load(2, 1, 6, -1, 0);
      push_n(2, 1);
      repeat (3) cycle();
      reset = 1'b1;
      flush();
      drive();
      repeat (3) cycle();
      reset = 1'b0;
      cycle();
      chk("mid_rst_grant", 32'(o_grant), 0);
      chk("mid_rst_sel", 32'(o_sel), 0);
      chk("mid_rst_busy", 32'(o_busy), 0);
      chk("mid_rst_xfer", 32'(o_xfer), 0);
      chk("mid_rst_credits", 32'(o_credits), 4);
      chk("mid_rst_err", 32'(o_credit_err), 0);
      chk("mid_rst_drained", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
